decode_cycle: RTL and testbench

ID stage of the 5-stage RV32I pipeline. It sits directly upstream of the execute stage. The block:
- decodes InstrD
- reads the 32x32 register file, with write-back port from W
- sign-extends the immediate
- registers all execute-stage inputs in the ID/EX pipeline register, with flush-to-bubble support

It also exports source register indices for the hazard unit.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/reg_file.sv | 53 +++++
 rtl/decode_cycle.sv | 157 +++++++++++++++
 tb/tb_decode_cycle.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I opcodes, control codes and ID/EX register layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic        alu_src;
        logic        mem_write;
        logic        result_src;
        logic        branch;
        logic [2:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } idex_t;

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : 2R/1W register file, x0 hardwired to zero, write-through bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr_en;

    assign w_wr_en = i_we && (i_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_rd] <= i_wd;
        end
    end

    // Bypass lets WB->ID in the same cycle resolve without a stall.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (i_rs1 != '0) begin
            o_rd1 = (w_wr_en && (i_rd == i_rs1)) ? i_wd : r_regs[i_rs1];
        end
        if (i_rs2 != '0) begin
            o_rd2 = (w_wr_en && (i_rd == i_rs2)) ? i_wd : r_regs[i_rs2];
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_cycle.sv
// ============================================================================
// Module      : decode_cycle
// Description : RV32I ID stage: decode, register read, immediate, ID/EX reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_cycle
    import riscv_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [DATA_W-1:0] PCD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic              RegWriteW,
    input  logic [4:0]        RDW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              FlushE,
    output logic              RegWriteE,
    output logic              ALU_SrcE,
    output logic              MemWriteE,
    output logic              ResultSrcE,
    output logic              BranchE,
    output logic [2:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1_E,
    output logic [DATA_W-1:0] RD2_E,
    output logic [DATA_W-1:0] Imm_Ext_E,
    output logic [4:0]        RD_E,
    output logic [4:0]        RS1_E,
    output logic [4:0]        RS2_E,
    output logic [DATA_W-1:0] PCE,
    output logic [DATA_W-1:0] PCPlus4E
);

    logic [6:0]        w_op;
    logic [2:0]        w_funct3;
    logic              w_funct7b5;
    logic [1:0]        w_imm_src;
    logic [1:0]        w_alu_op;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    idex_t             w_idex_d;
    idex_t             r_idex;

    assign w_op       = InstrD[6:0];
    assign w_funct3   = InstrD[14:12];
    assign w_funct7b5 = InstrD[30];

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .i_rs1 (InstrD[19:15]),
        .i_rs2 (InstrD[24:20]),
        .i_we  (RegWriteW),
        .i_rd  (RDW),
        .i_wd  (ResultW),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    always_comb begin
        w_idex_d  = '0;
        w_imm_src = IMM_I;
        w_alu_op  = ALUOP_ADD;

        case (w_op)
            OP_LW: begin
                w_idex_d.reg_write  = 1'b1;
                w_idex_d.alu_src    = 1'b1;
                w_idex_d.result_src = 1'b1;
            end
            OP_SW: begin
                w_imm_src          = IMM_S;
                w_idex_d.alu_src   = 1'b1;
                w_idex_d.mem_write = 1'b1;
            end
            OP_R: begin
                w_idex_d.reg_write = 1'b1;
                w_alu_op           = ALUOP_FUNC;
            end
            OP_I: begin
                w_idex_d.reg_write = 1'b1;
                w_idex_d.alu_src   = 1'b1;
                w_alu_op           = ALUOP_FUNC;
            end
            OP_BEQ: begin
                w_imm_src       = IMM_B;
                w_idex_d.branch = 1'b1;
                w_alu_op        = ALUOP_SUB;
            end
            default: ;
        endcase

        case (w_alu_op)
            ALUOP_SUB:  w_idex_d.alu_ctrl = ALU_SUB;
            ALUOP_FUNC: begin
                case (w_funct3)
                    // Only R-type carries funct7; addi with bit30 set stays add.
                    3'b000:  w_idex_d.alu_ctrl = ({w_op[5], w_funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_idex_d.alu_ctrl = ALU_SLT;
                    3'b110:  w_idex_d.alu_ctrl = ALU_OR;
                    3'b111:  w_idex_d.alu_ctrl = ALU_AND;
                    default: w_idex_d.alu_ctrl = ALU_ADD;
                endcase
            end
            default:    w_idex_d.alu_ctrl = ALU_ADD;
        endcase

        case (w_imm_src)
            IMM_I:   w_idex_d.imm = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   w_idex_d.imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   w_idex_d.imm = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            default: w_idex_d.imm = '0;
        endcase

        w_idex_d.rd1      = w_rd1;
        w_idex_d.rd2      = w_rd2;
        w_idex_d.rd       = InstrD[11:7];
        w_idex_d.rs1      = InstrD[19:15];
        w_idex_d.rs2      = InstrD[24:20];
        w_idex_d.pc       = PCD;
        w_idex_d.pc_plus4 = PCPlus4D;
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_idex_d;
        end
    end

    assign RegWriteE   = r_idex.reg_write;
    assign ALU_SrcE    = r_idex.alu_src;
    assign MemWriteE   = r_idex.mem_write;
    assign ResultSrcE  = r_idex.result_src;
    assign BranchE     = r_idex.branch;
    assign ALUControlE = r_idex.alu_ctrl;
    assign RD1_E       = r_idex.rd1;
    assign RD2_E       = r_idex.rd2;
    assign Imm_Ext_E   = r_idex.imm;
    assign RD_E        = r_idex.rd;
    assign RS1_E       = r_idex.rs1;
    assign RS2_E       = r_idex.rs2;
    assign PCE         = r_idex.pc;
    assign PCPlus4E    = r_idex.pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_decode_cycle.sv
// ============================================================================
// Module      : tb_decode_cycle
// Description : Scoreboard bench for decode_cycle against a table-driven model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_cycle;

    typedef struct {
        logic [31:0] v [14];
        bit          imm_valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, ALU_SrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E, RS1_E, RS2_E;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb_q[$];
    logic [31:0] model_rf [32];

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ALU_SrcE(ALU_SrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: decode table rows and immediates computed as signed integers.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] pc4, input logic we,
                                   input logic [4:0] wd, input logic [31:0] res);
        exp_t e;
        logic [8:0] row;
        int imm;
        logic [2:0] f3;
        logic [4:0] rs1, rs2;
        f3  = ins[14:12];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        case (ins[6:0])
            7'b0000011: row = 9'b1_00_1_0_1_0_00;
            7'b0100011: row = 9'b0_01_1_1_0_0_00;
            7'b0110011: row = 9'b1_00_0_0_0_0_10;
            7'b0010011: row = 9'b1_00_1_0_0_0_10;
            7'b1100011: row = 9'b0_10_0_0_0_1_01;
            default:    row = 9'b0;
        endcase
        e.imm_valid = (ins[6:0] != 7'b0110011);
        e.v[0] = 32'(row[8]);
        e.v[1] = 32'(row[5]);
        e.v[2] = 32'(row[4]);
        e.v[3] = 32'(row[3]);
        e.v[4] = 32'(row[2]);
        if (row[1:0] == 2'b01) e.v[5] = 1;
        else if (row[1:0] == 2'b10) begin
            if (f3 == 0)      e.v[5] = (ins[5] && ins[30]) ? 1 : 0;
            else if (f3 == 2) e.v[5] = 5;
            else if (f3 == 6) e.v[5] = 3;
            else if (f3 == 7) e.v[5] = 2;
            else              e.v[5] = 0;
        end else e.v[5] = 0;
        e.v[6] = (rs1 == 0) ? 0 : (we && wd == rs1) ? res : model_rf[rs1];
        e.v[7] = (rs2 == 0) ? 0 : (we && wd == rs2) ? res : model_rf[rs2];
        case (row[7:6])
            2'b00:   imm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
            2'b01:   imm = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
            2'b10:   imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                           + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            default: imm = 0;
        endcase
        e.v[8]  = imm;
        e.v[9]  = 32'(ins[11:7]);
        e.v[10] = 32'(rs1);
        e.v[11] = 32'(rs2);
        e.v[12] = pc;
        e.v[13] = pc4;
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic we, input logic [4:0] wd,
                        input logic [31:0] res, input logic fl, input logic r);
        exp_t e;
        logic [31:0] pc;
        @(negedge clk);
        pc        = $urandom & 32'hFFFF_FFFC;
        InstrD    = ins;
        PCD       = pc;
        PCPlus4D  = pc + 4;
        RegWriteW = we;
        RDW       = wd;
        ResultW   = res;
        FlushE    = fl;
        rst       = r;
        e = model(ins, pc, pc + 4, we, wd, res);
        if (r || fl) begin
            for (int i = 0; i < 14; i++) e.v[i] = 0;
            e.imm_valid = 1'b1;
        end
        if (r) begin
            for (int i = 0; i < 32; i++) model_rf[i] = 0;
        end else if (we && wd != 0) begin
            model_rf[wd] = res;
        end
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("RegWriteE",   32'(RegWriteE),   e.v[0]);
            chk("ALU_SrcE",    32'(ALU_SrcE),    e.v[1]);
            chk("MemWriteE",   32'(MemWriteE),   e.v[2]);
            chk("ResultSrcE",  32'(ResultSrcE),  e.v[3]);
            chk("BranchE",     32'(BranchE),     e.v[4]);
            chk("ALUControlE", 32'(ALUControlE), e.v[5]);
            chk("RD1_E",       RD1_E,            e.v[6]);
            chk("RD2_E",       RD2_E,            e.v[7]);
            if (e.imm_valid) chk("Imm_Ext_E", Imm_Ext_E, e.v[8]);
            chk("RD_E",        32'(RD_E),        e.v[9]);
            chk("RS1_E",       32'(RS1_E),       e.v[10]);
            chk("RS2_E",       32'(RS2_E),       e.v[11]);
            chk("PCE",         PCE,              e.v[12]);
            chk("PCPlus4E",    PCPlus4E,         e.v[13]);
        end
    end

    initial begin
        logic [6:0]  ops [7];
        logic [31:0] ins;
        int          wait_cyc;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1111111, 7'b0000000};
        for (int i = 0; i < 32; i++) model_rf[i] = 0;
        rst = 1'b1; InstrD = 0; PCD = 0; PCPlus4D = 0;
        RegWriteW = 0; RDW = 0; ResultW = 0; FlushE = 0;

        step(32'h002081B3, 1, 5'd1, 32'h55, 0, 1);
        step(32'h002081B3, 0, 5'd0, 32'h0, 1, 1);
        step(32'h002081B3, 0, 5'd0, 32'h0, 0, 0);
        step(32'h00000013, 1, 5'd1, 32'd5, 0, 0);
        step(32'h00000013, 1, 5'd2, 32'd7, 0, 0);
        step(32'h002081B3, 0, 5'd0, 32'h0, 0, 0);
        step(32'h002081B3, 1, 5'd1, 32'hDEADBEEF, 0, 0);
        step(32'h002001B3, 1, 5'd0, 32'h12345678, 0, 0);
        step(32'h00000033, 0, 5'd0, 32'h0, 0, 0);
        step(32'hFFC0A283, 0, 5'd0, 32'h0, 0, 0);
        step(32'h00512423, 0, 5'd0, 32'h0, 0, 0);
        step(32'hFE208CE3, 0, 5'd0, 32'h0, 0, 0);
        step(32'h402081B3, 0, 5'd0, 32'h0, 0, 0);
        step(32'h002081B3, 1, 5'd4, 32'd9, 1, 0);
        step(32'h00400233, 0, 5'd0, 32'h0, 0, 0);
        step(32'h0000007F, 0, 5'd0, 32'h0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 6)];
            step(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
        end

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
